tlb_op_ctrl: RTL and testbench

- Initiator side of the TLB maintenance interface of the address translation unit.
- Accepts one TLB instruction at a time (TLBSRCH, TLBRD, TLBWR, TLBFILL, INVTLB) from the EX/MEM stage.
- Sequences the search/read/write/fill/invalidate strobes toward the translation unit and collects search and read results.
- Issues the resulting CSR writes (TLBIDX, TLBEHI, TLBELO0/1, ASID) and signals completion to the pipeline.

---
 rtl/tlb_op_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_tlb_op_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_op_ctrl.sv
// TLB maintenance initiator: sequences TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB
// toward the translation unit and produces the resulting CSR writes.
module tlb_op_ctrl #(
    parameter int unsigned TLBNUM    = 32,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    localparam int unsigned IDXW     = $clog2(TLBNUM)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            op_valid,
    output logic            op_ready,
    input  logic [2:0]      op_code,
    input  logic [4:0]      inv_op,
    input  logic [9:0]      inv_asid,
    input  logic [18:0]     inv_vpn,
    output logic            op_done,
    output logic            op_illegal,
    input  logic [31:0]     csr_tlbidx,
    output logic            srch_en,
    input  logic            srch_finish,
    input  logic            srch_found,
    input  logic [IDXW-1:0] srch_index,
    input  logic            rd_e,
    input  logic            rd_g,
    input  logic [5:0]      rd_ps,
    input  logic [9:0]      rd_asid,
    input  logic [18:0]     rd_vppn,
    input  logic [25:0]     rd_lo0,
    input  logic [25:0]     rd_lo1,
    output logic            tlb_wen,
    output logic            tlb_fill_en,
    output logic [IDXW-1:0] rand_index,
    output logic            tlbinv_en,
    output logic [4:0]      tlbinv_op,
    output logic [9:0]      tlbinv_asid,
    output logic [18:0]     tlbinv_vpn,
    output logic            tlbidx_we,
    output logic [31:0]     tlbidx_wdata,
    output logic            tlbehi_we,
    output logic [31:0]     tlbehi_wdata,
    output logic            tlbelo0_we,
    output logic [31:0]     tlbelo0_wdata,
    output logic            tlbelo1_we,
    output logic [31:0]     tlbelo1_wdata,
    output logic            asid_we,
    output logic [9:0]      asid_wdata
);

    localparam logic [2:0] OP_SRCH = 3'd0;
    localparam logic [2:0] OP_RD   = 3'd1;
    localparam logic [2:0] OP_WR   = 3'd2;
    localparam logic [2:0] OP_FILL = 3'd3;
    localparam logic [2:0] OP_INV  = 3'd4;
    localparam logic [4:0] INV_MAX = 5'd6;

    typedef enum logic [2:0] {
        IDLE, SRCH_REQ, SRCH_WAIT, RD_ISSUE, RD_CAP, EXEC, DONE_NOP
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  op_q;
    logic [4:0]  inv_op_q;
    logic [9:0]  inv_asid_q;
    logic [18:0] inv_vpn_q;
    logic [15:0] lfsr_q;
    logic        kill;
    logic        accept;

    // Read-port lo word {ppn, plv, mat, d, v} to TLBELO layout
    function automatic logic [31:0] to_elo(input logic [25:0] lo, input logic g);
        return {4'b0, lo[25:6], 1'b0, g, lo[3:2], lo[5:4], lo[1], lo[0]};
    endfunction

    assign kill        = reset | flush;
    assign op_ready    = (state_q == IDLE);
    assign accept      = op_valid & op_ready & ~kill;
    assign rand_index  = lfsr_q[IDXW-1:0];
    assign tlbinv_op   = inv_op_q;
    assign tlbinv_asid = inv_asid_q;
    assign tlbinv_vpn  = inv_vpn_q;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Latch the accepted instruction and its INVTLB operands
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q       <= 3'd0;
            inv_op_q   <= 5'd0;
            inv_asid_q <= 10'd0;
            inv_vpn_q  <= 19'd0;
        end else if (accept) begin
            op_q       <= op_code;
            inv_op_q   <= inv_op;
            inv_asid_q <= inv_asid;
            inv_vpn_q  <= inv_vpn;
        end
    end

    // Free-running Fibonacci LFSR (taps 16,14,13,11) for TLBFILL index
    always_ff @(posedge clk) begin
        if (reset) lfsr_q <= LFSR_SEED;
        else       lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    // Next state, strobes and CSR write data; flush/reset override everything
    always_comb begin
        state_d       = state_q;
        op_done       = 1'b0;
        op_illegal    = 1'b0;
        srch_en       = 1'b0;
        tlb_wen       = 1'b0;
        tlb_fill_en   = 1'b0;
        tlbinv_en     = 1'b0;
        tlbidx_we     = 1'b0;
        tlbehi_we     = 1'b0;
        tlbelo0_we    = 1'b0;
        tlbelo1_we    = 1'b0;
        asid_we       = 1'b0;
        tlbidx_wdata  = csr_tlbidx;
        tlbehi_wdata  = 32'd0;
        tlbelo0_wdata = 32'd0;
        tlbelo1_wdata = 32'd0;
        asid_wdata    = 10'd0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (op_code)
                        OP_SRCH:                 state_d = SRCH_REQ;
                        OP_RD:                   state_d = RD_ISSUE;
                        OP_WR, OP_FILL, OP_INV:  state_d = EXEC;
                        default:                 state_d = DONE_NOP;
                    endcase
                end
            end
            SRCH_REQ: begin
                srch_en = 1'b1;
                state_d = SRCH_WAIT;
            end
            SRCH_WAIT: begin
                if (srch_finish) begin
                    tlbidx_we = 1'b1;
                    op_done   = 1'b1;
                    if (srch_found) begin
                        tlbidx_wdata[IDXW-1:0] = srch_index;
                        tlbidx_wdata[31]       = 1'b0;
                    end else begin
                        tlbidx_wdata[31] = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            RD_ISSUE: begin
                state_d = RD_CAP;
            end
            RD_CAP: begin
                tlbidx_we  = 1'b1;
                tlbehi_we  = 1'b1;
                tlbelo0_we = 1'b1;
                tlbelo1_we = 1'b1;
                asid_we    = 1'b1;
                op_done    = 1'b1;
                if (rd_e) begin
                    tlbidx_wdata[29:24] = rd_ps;
                    tlbidx_wdata[31]    = 1'b0;
                    tlbehi_wdata        = {rd_vppn, 13'b0};
                    tlbelo0_wdata       = to_elo(rd_lo0, rd_g);
                    tlbelo1_wdata       = to_elo(rd_lo1, rd_g);
                    asid_wdata          = rd_asid;
                end else begin
                    tlbidx_wdata[29:24] = 6'd0;
                    tlbidx_wdata[31]    = 1'b1;
                end
                state_d = IDLE;
            end
            EXEC: begin
                op_done = 1'b1;
                case (op_q)
                    OP_WR:   tlb_wen     = 1'b1;
                    OP_FILL: tlb_fill_en = 1'b1;
                    OP_INV: begin
                        if (inv_op_q > INV_MAX) op_illegal = 1'b1;
                        else                    tlbinv_en  = 1'b1;
                    end
                    default: ;
                endcase
                state_d = IDLE;
            end
            DONE_NOP: begin
                op_done = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (kill) begin
            state_d     = IDLE;
            op_done     = 1'b0;
            op_illegal  = 1'b0;
            srch_en     = 1'b0;
            tlb_wen     = 1'b0;
            tlb_fill_en = 1'b0;
            tlbinv_en   = 1'b0;
            tlbidx_we   = 1'b0;
            tlbehi_we   = 1'b0;
            tlbelo0_we  = 1'b0;
            tlbelo1_we  = 1'b0;
            asid_we     = 1'b0;
        end
    end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Self-checking bench for tlb_op_ctrl: vector table + scoreboard, plus
// hand sequences for flush, reset mid-op, back-to-back and LFSR behaviour.
module tb_tlb_op_ctrl;

    localparam int unsigned IDXW = 5;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam logic [2:0]  C_SRCH = 3'd0, C_RD = 3'd1, C_WR = 3'd2, C_FILL = 3'd3, C_INV = 3'd4;

    logic clk = 1'b0, reset = 1'b1, flush = 1'b0, op_valid = 1'b0;
    logic op_ready, op_done, op_illegal, srch_en;
    logic [2:0] op_code = 3'd0;
    logic [4:0] inv_op = 5'd0;
    logic [9:0] inv_asid = 10'd0;
    logic [18:0] inv_vpn = 19'd0;
    logic [31:0] csr_tlbidx = 32'd0;
    logic srch_finish = 1'b0, srch_found = 1'b0;
    logic [IDXW-1:0] srch_index = '0;
    logic rd_e = 1'b0, rd_g = 1'b0;
    logic [5:0] rd_ps = 6'd0;
    logic [9:0] rd_asid = 10'd0;
    logic [18:0] rd_vppn = 19'd0;
    logic [25:0] rd_lo0 = 26'd0, rd_lo1 = 26'd0;
    logic tlb_wen, tlb_fill_en, tlbinv_en;
    logic [IDXW-1:0] rand_index;
    logic [4:0] tlbinv_op;
    logic [9:0] tlbinv_asid;
    logic [18:0] tlbinv_vpn;
    logic tlbidx_we, tlbehi_we, tlbelo0_we, tlbelo1_we, asid_we;
    logic [31:0] tlbidx_wdata, tlbehi_wdata, tlbelo0_wdata, tlbelo1_wdata;
    logic [9:0] asid_wdata;

    tlb_op_ctrl #(.TLBNUM(32), .LFSR_SEED(SEED)) dut (
        .clk(clk), .reset(reset), .flush(flush), .op_valid(op_valid), .op_ready(op_ready),
        .op_code(op_code), .inv_op(inv_op), .inv_asid(inv_asid), .inv_vpn(inv_vpn),
        .op_done(op_done), .op_illegal(op_illegal), .csr_tlbidx(csr_tlbidx),
        .srch_en(srch_en), .srch_finish(srch_finish), .srch_found(srch_found),
        .srch_index(srch_index), .rd_e(rd_e), .rd_g(rd_g), .rd_ps(rd_ps),
        .rd_asid(rd_asid), .rd_vppn(rd_vppn), .rd_lo0(rd_lo0), .rd_lo1(rd_lo1),
        .tlb_wen(tlb_wen), .tlb_fill_en(tlb_fill_en), .rand_index(rand_index),
        .tlbinv_en(tlbinv_en), .tlbinv_op(tlbinv_op), .tlbinv_asid(tlbinv_asid),
        .tlbinv_vpn(tlbinv_vpn), .tlbidx_we(tlbidx_we), .tlbidx_wdata(tlbidx_wdata),
        .tlbehi_we(tlbehi_we), .tlbehi_wdata(tlbehi_wdata), .tlbelo0_we(tlbelo0_we),
        .tlbelo0_wdata(tlbelo0_wdata), .tlbelo1_we(tlbelo1_we), .tlbelo1_wdata(tlbelo1_wdata),
        .asid_we(asid_we), .asid_wdata(asid_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  code;
        logic [4:0]  iop;
        logic [9:0]  iasid;
        logic [18:0] ivpn;
        logic [31:0] csr;
        int          dly;
        logic        found;
        logic [4:0]  sidx;
        logic        e, g;
        logic [5:0]  ps;
        logic [9:0]  asid;
        logic [18:0] vppn;
        logic [25:0] lo0, lo1;
        logic [7:0]  we;   // {idx, ehi, elo0, elo1, asid, wen, fill, inv}
        logic        ill;
        int          lat;
        logic [31:0] eidx, ehi, elo0, elo1;
        logic [9:0]  easid;
        int          acc;
    } vec_t;

    vec_t sb[$];
    vec_t tbl[14];
    logic [4:0] fills[$];
    int checks = 0, errors = 0, cyc = 0, done_cnt = 0, last_done = 0;
    logic [15:0] m;

    // Reference LFSR and cycle counter
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) m <= SEED;
        else       m <= {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] we_vec();
        return {tlbidx_we, tlbehi_we, tlbelo0_we, tlbelo1_we, asid_we, tlb_wen, tlb_fill_en, tlbinv_en};
    endfunction

    function automatic vec_t v_base(input logic [2:0] code, input int lat, input logic [7:0] we);
        vec_t v;
        v = '{default: '0};
        v.code = code; v.lat = lat; v.we = we;
        return v;
    endfunction

    function automatic vec_t v_srch(input logic [31:0] csr, input int dly, input logic found,
                                    input logic [4:0] idx, input logic [31:0] eidx);
        vec_t v;
        v = v_base(C_SRCH, 1 + dly, 8'b1000_0000);
        v.csr = csr; v.dly = dly; v.found = found; v.sidx = idx; v.eidx = eidx;
        return v;
    endfunction

    function automatic vec_t v_rd(input logic [31:0] csr, input logic e, input logic g,
                                  input logic [5:0] ps, input logic [9:0] asid, input logic [18:0] vppn,
                                  input logic [25:0] lo0, input logic [25:0] lo1,
                                  input logic [31:0] eidx, input logic [31:0] ehi,
                                  input logic [31:0] elo0, input logic [31:0] elo1, input logic [9:0] easid);
        vec_t v;
        v = v_base(C_RD, 2, 8'b1111_1000);
        v.csr = csr; v.e = e; v.g = g; v.ps = ps; v.asid = asid; v.vppn = vppn;
        v.lo0 = lo0; v.lo1 = lo1; v.eidx = eidx; v.ehi = ehi; v.elo0 = elo0; v.elo1 = elo1;
        v.easid = easid;
        return v;
    endfunction

    function automatic vec_t v_op(input logic [2:0] code, input logic [4:0] iop, input logic [9:0] iasid,
                                  input logic [18:0] ivpn, input logic [7:0] we, input logic ill);
        vec_t v;
        v = v_base(code, 1, we);
        v.iop = iop; v.iasid = iasid; v.ivpn = ivpn; v.ill = ill;
        return v;
    endfunction

    // Monitor: invariants every cycle, scoreboard pop on op_done
    always @(negedge clk) begin
        vec_t e;
        if (!reset) begin
            if (tlb_wen && tlb_fill_en) chk("wen_fill_overlap", 32'd1, 32'd0);
            if (!op_done) chk("strobe_without_done", 32'(we_vec()), 32'd0);
            if (tlb_fill_en) begin
                chk("rand_index", 32'(rand_index), 32'(m[4:0]));
                fills.push_back(rand_index);
            end
            if (op_done) begin
                done_cnt++;
                last_done = cyc;
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("latency", 32'(cyc - e.acc), 32'(e.lat));
                    chk("strobes", 32'(we_vec()), 32'(e.we));
                    chk("op_illegal", 32'(op_illegal), 32'(e.ill));
                    if (e.we[7]) chk("tlbidx_wdata", tlbidx_wdata, e.eidx);
                    if (e.we[6]) begin
                        chk("tlbehi_wdata", tlbehi_wdata, e.ehi);
                        chk("tlbelo0_wdata", tlbelo0_wdata, e.elo0);
                        chk("tlbelo1_wdata", tlbelo1_wdata, e.elo1);
                        chk("asid_wdata", 32'(asid_wdata), 32'(e.easid));
                    end
                    if (e.we[0]) begin
                        chk("tlbinv_op", 32'(tlbinv_op), 32'(e.iop));
                        chk("tlbinv_asid", 32'(tlbinv_asid), 32'(e.iasid));
                        chk("tlbinv_vpn", 32'(tlbinv_vpn), 32'(e.ivpn));
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one instruction, service the search handshake, wait for completion
    task automatic run(input vec_t v, output int acc);
        int n = 0;
        while (!op_ready && n < 50) begin step(); n++; end
        acc = cyc;
        if (!op_ready) begin
            chk("ready_timeout", 32'd0, 32'd1);
            return;
        end
        op_code = v.code; inv_op = v.iop; inv_asid = v.iasid; inv_vpn = v.ivpn;
        csr_tlbidx = v.csr; rd_e = v.e; rd_g = v.g; rd_ps = v.ps; rd_asid = v.asid;
        rd_vppn = v.vppn; rd_lo0 = v.lo0; rd_lo1 = v.lo1;
        op_valid = 1'b1;
        v.acc = cyc;
        sb.push_back(v);
        step();
        op_valid = 1'b0;
        if (v.code == C_SRCH) begin
            chk("srch_en_req", 32'(srch_en), 32'd1);
            for (int i = 0; i < v.dly; i++) begin
                step();
                chk("srch_en_wait", 32'(srch_en), 32'd0);
            end
            srch_found = v.found; srch_index = v.sidx; srch_finish = 1'b1;
            step();
            srch_finish = 1'b0;
        end
        n = 0;
        while (sb.size() != 0 && n < 20) begin step(); n++; end
        if (sb.size() != 0) begin
            chk("done_timeout", 32'd0, 32'd1);
            sb.delete();
        end
    endtask

    initial begin
        int acc, acc2, dc;
        logic same;
        tbl[0]  = v_srch(32'h8000_0003, 2, 1'b1, 5'd5,  32'h0000_0005);
        tbl[1]  = v_srch(32'h0000_0007, 3, 1'b0, 5'd9,  32'h8000_0007);
        tbl[2]  = v_srch(32'hBF00_001F, 1, 1'b1, 5'd2,  32'h3F00_0002);
        tbl[3]  = v_rd(32'h0000_0004, 1'b1, 1'b1, 6'd12, 10'h02A, 19'h1_2345,
                       {20'hABCDE, 2'd3, 2'd1, 1'b1, 1'b1}, {20'h12345, 2'd0, 2'd2, 1'b0, 1'b1},
                       32'h0C00_0004, 32'h2468_A000, 32'h0ABC_DE5F, 32'h0123_4561, 10'h02A);
        tbl[4]  = v_rd(32'h0C00_0009, 1'b0, 1'b1, 6'd12, 10'h155, 19'h5_5555,
                       26'h3FF_FFFF, 26'h155_5555,
                       32'h8000_0009, 32'h0, 32'h0, 32'h0, 10'h000);
        tbl[5]  = v_rd(32'h8000_0001, 1'b1, 1'b0, 6'h15, 10'h3FF, 19'h7_FFFF,
                       26'h3FF_FFFF, 26'h0,
                       32'h1500_0001, 32'hFFFF_E000, 32'h0FFF_FF3F, 32'h0, 10'h3FF);
        tbl[6]  = v_op(C_WR,   5'd0,  10'h000, 19'h0,     8'b0000_0100, 1'b0);
        tbl[7]  = v_op(C_FILL, 5'd0,  10'h000, 19'h0,     8'b0000_0010, 1'b0);
        tbl[8]  = v_op(C_INV,  5'd5,  10'h011, 19'h0_0F00, 8'b0000_0001, 1'b0);
        tbl[9]  = v_op(C_INV,  5'd7,  10'h011, 19'h0_0F00, 8'b0000_0000, 1'b1);
        tbl[10] = v_op(3'd6,   5'd0,  10'h000, 19'h0,     8'b0000_0000, 1'b0);
        tbl[11] = v_op(C_INV,  5'd6,  10'h3FF, 19'h7_FFFF, 8'b0000_0001, 1'b0);
        tbl[12] = v_op(C_INV,  5'd31, 10'h155, 19'h1_2345, 8'b0000_0000, 1'b1);
        tbl[13] = v_op(3'd7,   5'd0,  10'h000, 19'h0,     8'b0000_0000, 1'b0);

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("reset_op_ready", 32'(op_ready), 32'd1);
        chk("reset_op_done", 32'(op_done), 32'd0);
        chk("reset_strobes", 32'({we_vec(), srch_en}), 32'd0);
        chk("reset_inv_regs", 32'({tlbinv_op, tlbinv_asid}), 32'd0);
        chk("reset_inv_vpn", 32'(tlbinv_vpn), 32'd0);
        chk("reset_rand_index", 32'(rand_index), 32'h1);

        for (int i = 0; i < 14; i++) run(tbl[i], acc);

        // WR then FILL back-to-back: fill completes three cycles after WR accept
        run(v_op(C_WR, 5'd0, 10'h0, 19'h0, 8'b0000_0100, 1'b0), acc);
        run(v_op(C_FILL, 5'd0, 10'h0, 19'h0, 8'b0000_0010, 1'b0), acc2);
        chk("b2b_fill_accept", 32'(acc2 - acc), 32'd2);
        chk("b2b_fill_done", 32'(last_done - acc), 32'd3);

        // Four fills spaced three cycles apart must not all see the same index
        fills.delete();
        for (int i = 0; i < 4; i++) begin
            run(v_op(C_FILL, 5'd0, 10'h0, 19'h0, 8'b0000_0010, 1'b0), acc);
            step();
        end
        same = 1'b1;
        for (int i = 1; i < fills.size(); i++) if (fills[i] != fills[0]) same = 1'b0;
        chk("fill_count", 32'(fills.size()), 32'd4);
        chk("rand_index_varies", 32'(same), 32'd0);

        // Flush in SRCH_WAIT coinciding with srch_finish: result dropped
        dc = done_cnt;
        op_code = C_SRCH; csr_tlbidx = 32'h0000_0007; op_valid = 1'b1;
        step();
        op_valid = 1'b0;
        chk("flush_srch_en", 32'(srch_en), 32'd1);
        step();
        flush = 1'b1; srch_finish = 1'b1; srch_found = 1'b1; srch_index = 5'd3;
        #1;
        chk("flush_tlbidx_we", 32'(tlbidx_we), 32'd0);
        chk("flush_op_done", 32'(op_done), 32'd0);
        step();
        flush = 1'b0; srch_finish = 1'b0;
        chk("flush_op_ready", 32'(op_ready), 32'd1);
        step();
        srch_finish = 1'b1;
        step();
        srch_finish = 1'b0;
        repeat (2) step();
        chk("flush_result_dropped", 32'(done_cnt - dc), 32'd0);

        // op_valid together with flush in IDLE is not accepted
        dc = done_cnt;
        op_code = C_WR; op_valid = 1'b1; flush = 1'b1;
        step();
        op_valid = 1'b0; flush = 1'b0;
        chk("flush_no_accept", 32'(op_ready), 32'd1);
        repeat (2) step();
        chk("flush_no_accept_done", 32'(done_cnt - dc), 32'd0);

        // Reset during RD_CAP: no completion, LFSR reseeded
        dc = done_cnt;
        op_code = C_RD; op_valid = 1'b1; rd_e = 1'b1;
        step();
        op_valid = 1'b0;
        step();
        reset = 1'b1;
        #1;
        chk("reset_mid_done", 32'(op_done), 32'd0);
        chk("reset_mid_we", 32'(we_vec()), 32'd0);
        step();
        reset = 1'b0;
        chk("reset_mid_ready", 32'(op_ready), 32'd1);
        chk("reset_mid_reseed", 32'(rand_index), 32'h1);
        repeat (2) step();
        chk("reset_mid_no_done", 32'(done_cnt - dc), 32'd0);
        run(v_op(C_FILL, 5'd0, 10'h0, 19'h0, 8'b0000_0010, 1'b0), acc);
        run(tbl[0], acc);

        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
